lc3_mem_arbiter: RTL

- Shares one single-port synchronous memory between two LC3 memory requesters, for example two cores or a core plus a loader.
- Each requester presents the memory interface of a core: address, write data and write enable. The arbiter serialises these requests onto the memory port and returns read data with a one-cycle acknowledge.
- Arbitration is round-robin, with one transaction in flight at a time.
- Sits between the core MAR/MDR/memwe outputs and the memory model.

---
 rtl/lc3_mem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous memory between
// two LC3 requesters, one transaction in flight, with a one-cycle ack per completion.
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  state_t            state_q;
  state_t            state_d;
  logic              grant_valid;
  logic              grant_idx;
  logic              rd_capture;
  logic              owner_q;
  logic              last_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [2:0]        cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // On a conflict the requester that did not win last time gets the grant.
  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    rd_capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_valid = 1'b1;
          grant_idx   = (req0 && req1) ? ~last_q : req1;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          rd_capture = ~we_q;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= 3'd0;
    end else begin
      if (grant_valid) begin
        owner_q <= grant_idx;
        we_q    <= grant_idx ? we1 : we0;
        addr_q  <= grant_idx ? addr1 : addr0;
        wdata_q <= grant_idx ? wdata1 : wdata0;
      end
      cnt_q <= (state_q == WAIT) ? cnt_q + 3'd1 : 3'd0;
      if (rd_capture) begin
        if (owner_q) begin
          rdata1_q <= mem_rdata;
        end else begin
          rdata0_q <= mem_rdata;
        end
      end
      if (state_q == DONE) begin
        last_q <= owner_q;
      end
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign ack0      = (state_q == DONE) && !owner_q;
  assign ack1      = (state_q == DONE) && owner_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule
